// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity helper.
// Imported by both the transmit stage and the bit timer it shares with the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running per-bit counter with synchronous clear; tick marks the last cycle of a bit.
// Kept generic so the receive stage can reuse it unchanged.
module uart_bit_timer import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

  logic [CNT_W-1:0] count_r;

  // Bit-period counter: held at zero while cleared, wraps after the last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= ZERO;
    end else if (clear) begin
      count_r <= ZERO;
    end else if (count_r == LAST) begin
      count_r <= ZERO;
    end else begin
      count_r <= count_r + ONE;
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO through its registered read port:
// start bit, 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          state_r, state_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [2:0]           bit_idx_r, bit_idx_s;
  logic                 parity_r, parity_s;
  logic                 tx_r, tx_s;
  logic                 rd_en_r;
  logic                 busy_r;
  logic                 timer_clear_s;
  logic                 tick_s;

  // The timer idles at zero until START so the start bit gets a full period.
  assign timer_clear_s = (state_r == IDLE) || (state_r == REQ) || (state_r == WAIT);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear_s),
    .tick (tick_s)
  );

  // Next-state, shift register, bit index and parity; tx is derived from the next state.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_idx_s = bit_idx_r;
    parity_s  = parity_r;
    tx_s      = STOP_LEVEL;
    case (state_r)
      IDLE: begin
        if (!fifo_empty) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        state_s = WAIT;
      end
      WAIT: begin
        shift_s   = fifo_rd_data;
        parity_s  = even_parity(fifo_rd_data);
        bit_idx_s = 3'd0;
        state_s   = START;
      end
      START: begin
        if (tick_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_s = PARITY;
            end else begin
              state_s = STOP;
            end
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = parity_s;
      default: tx_s = STOP_LEVEL;
    endcase
  end

  // State and datapath registers; outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_BITS{1'b0}};
      bit_idx_r <= 3'd0;
      parity_r  <= 1'b0;
      tx_r      <= STOP_LEVEL;
      rd_en_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_idx_r <= bit_idx_s;
      parity_r  <= parity_s;
      tx_r      <= tx_s;
      rd_en_r   <= (state_s == REQ);
      busy_r    <= (state_s != IDLE);
    end
  end

  assign tx         = tx_r;
  assign fifo_rd_en = rd_en_r;
  assign busy       = busy_r;
  assign frame_done = (state_r == STOP) && tick_s;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two transmitters (no parity / even parity) fed identical bytes from
// a FIFO model; a monitor captures each tx frame and compares it to an ideal waveform.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] fifo_empty, fifo_rd_en, tx, busy, frame_done;
  logic [7:0] rd_data [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_push = 0;

  logic [7:0]  fmem [2][256];
  logic [7:0]  smem [2][256];
  int          fwr [2], frd [2], swr [2], srd [2];
  bit          in_frame [2];
  logic        prev_tx [2];
  bit          rd_en_prev [2];
  bit          busy_bad [2];
  int          wlen [2], start_gap [2], last_done [2], pop_gap [2], last_pop [2], frames [2];
  logic [63:0] wave [2];
  logic [7:0]  last_byte [2];

  assign fifo_empty[0] = (fwr[0] == frd[0]);
  assign fifo_empty[1] = (fwr[1] == frd[1]);

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[0]), .fifo_rd_data(rd_data[0]),
    .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[1]), .fifo_rd_data(rd_data[1]),
    .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Ideal line waveform of one frame, CPB samples per bit.
  function automatic logic [63:0] expected_wave(input logic [7:0] b, input int par);
    logic [63:0] w;
    logic        bits [$];
    int          ones;
    w = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par != 0) bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (int c = 0; c < CPB; c++) w[k*CPB + c] = bits[k];
    return w;
  endfunction

  task automatic push_both(input logic [7:0] b);
    for (int p = 0; p < 2; p++) begin
      fmem[p][fwr[p] % 256] = b;
      fwr[p]++;
    end
    n_push++;
  endtask

  function automatic bit all_idle();
    bit ok;
    ok = 1'b1;
    for (int p = 0; p < 2; p++)
      if (fwr[p] != frd[p] || swr[p] != srd[p] || busy[p] || in_frame[p]) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!all_idle() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 5000), 64'd1);
  endtask

  // FIFO model (pops on rd_en, pushes expectation) and tx frame monitor.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (reset) begin
          in_frame[p] = 1'b0;
          prev_tx[p]  = 1'b1;
        end else begin
          if (fifo_rd_en[p]) begin
            check($sformatf("rd_en_single_%0d", p), 64'(rd_en_prev[p]), 64'd0);
            check($sformatf("pop_when_empty_%0d", p), 64'(fifo_empty[p]), 64'd0);
            if (fwr[p] != frd[p]) begin
              rd_data[p] = fmem[p][frd[p] % 256];
              frd[p]++;
              smem[p][swr[p] % 256] = rd_data[p];
              swr[p]++;
              pop_gap[p]  = cyc - last_pop[p];
              last_pop[p] = cyc;
            end
          end
          if (!in_frame[p] && prev_tx[p] && !tx[p]) begin
            in_frame[p]  = 1'b1;
            wlen[p]      = 0;
            wave[p]      = '0;
            busy_bad[p]  = 1'b0;
            start_gap[p] = cyc - last_done[p];
            check($sformatf("start_after_pop_%0d", p), 64'(cyc - last_pop[p]), 64'd2);
          end
          if (in_frame[p]) begin
            if (wlen[p] < 64) wave[p][wlen[p]] = tx[p];
            if (!busy[p]) busy_bad[p] = 1'b1;
            wlen[p]++;
          end
          if (frame_done[p]) begin
            if (!in_frame[p] || srd[p] == swr[p]) begin
              check($sformatf("frame_done_spurious_%0d", p), 64'd1, 64'd0);
            end else begin
              b = smem[p][srd[p] % 256];
              srd[p]++;
              frames[p]++;
              last_byte[p] = b;
              check($sformatf("frame_len_%0d", p), 64'(wlen[p]), 64'((10 + p) * CPB));
              check($sformatf("frame_wave_%0d_byte_%0h", p, b), wave[p], expected_wave(b, p));
              check($sformatf("frame_busy_%0d", p), 64'(busy_bad[p]), 64'd0);
            end
            in_frame[p]  = 1'b0;
            last_done[p] = cyc;
          end
          prev_tx[p] = tx[p];
        end
        rd_en_prev[p] = fifo_rd_en[p];
      end
    end
  end

  initial begin
    int n;
    int base0;
    bit bad_tx, bad_busy, bad_rd;
    rd_data[0] = 8'h00;
    rd_data[1] = 8'h00;
    reset = 1'b1;

    // Reset held with the FIFO non-empty: quiet outputs, no pop.
    push_both(8'hA5);
    repeat (6) begin
      @(negedge clk);
      check("rst_tx", 64'(tx), 64'd3);
      check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
    end
    check("rst_no_pop", 64'(frd[0] + frd[1]), 64'd0);
    reset = 1'b0;

    // Single byte 0xA5.
    wait_idle("a5_timeout");
    check("a5_frames0", 64'(frames[0]), 64'd1);
    check("a5_frames1", 64'(frames[1]), 64'd1);

    // Back-to-back 0x55, 0xAA.
    push_both(8'h55);
    push_both(8'hAA);
    wait_idle("b2b_timeout");
    for (int p = 0; p < 2; p++) begin
      check($sformatf("b2b_pop_gap_%0d", p), 64'(pop_gap[p]), 64'(3 + (10 + p) * CPB));
      check($sformatf("b2b_high_gap_%0d", p), 64'(start_gap[p] - 1), 64'd3);
    end

    // Parity on 0x07.
    push_both(8'h07);
    wait_idle("par_timeout");
    check("par07_bit", 64'(wave[1][9*CPB]), 64'd1);
    check("par07_len", 64'(wlen[1]), 64'd44);

    // Reset during data bit 3 of 0xC3, then 0x5A must go out in full.
    base0 = frames[0];
    push_both(8'hC3);
    push_both(8'h5A);
    n = 0;
    while (!in_frame[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_start_seen", 64'(in_frame[0]), 64'd1);
    repeat (4 * CPB + 1) @(negedge clk);
    check("mid_pre_reset_tx", 64'(tx[0]), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("async_tx", 64'(tx), 64'd3);
    check("async_busy", 64'(busy), 64'd0);
    for (int p = 0; p < 2; p++) srd[p] = swr[p];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_idle("post_rst_timeout");
    check("post_rst_frames", 64'(frames[0] - base0), 64'd1);
    check("post_rst_byte0", 64'(last_byte[0]), 64'h5A);
    check("post_rst_byte1", 64'(last_byte[1]), 64'h5A);

    // FIFO empty for 100 cycles.
    bad_tx = 1'b0;
    bad_busy = 1'b0;
    bad_rd = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx != 2'b11) bad_tx = 1'b1;
      if (busy != 2'b00) bad_busy = 1'b1;
      if (fifo_rd_en != 2'b00) bad_rd = 1'b1;
    end
    check("empty_tx_high", 64'(bad_tx), 64'd0);
    check("empty_busy_low", 64'(bad_busy), 64'd0);
    check("empty_no_rd_en", 64'(bad_rd), 64'd0);

    // Random bytes with random spacing, including bursts.
    for (int i = 0; i < 30; i++) begin
      push_both(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle("rand_timeout");
    check("rand_frames0", 64'(frames[0]), 64'(n_push - 1));
    check("rand_frames1", 64'(frames[1]), 64'(n_push - 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
